jk_excite_seq: RTL
==================

Name: jk_excite_seq

Overview:
- Stimulus-side counterpart of the JK flip-flop interface: drives j/k into a jk_ff and reads q back.
- Accepts target q patterns over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each pattern MSB-first and computes the JK excitation needed to move q to each target bit, one bit per cycle.
- Checks the returned q against an internal model and counts mismatches. Used in self-checking environments and as a reusable pattern driver for JK-based register chains.

Parameters:
- PAT_W, 8, width of one target pattern word
- LEN_W, 4, width of pattern length field; valid lengths 1..PAT_W
- DEPTH, 4, pattern FIFO depth (power of 2, >=2)
- USE_TOGGLE, 0, 1: transitions driven as j=k=1; 0: transitions driven as set/reset
- ERR_W, 8, width of saturating mismatch counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- pat_valid  in  1  pattern offer
- pat_ready  out  1  FIFO not full
- pat_data  in  PAT_W  target q bits, MSB sent first
- pat_len  in  LEN_W  number of bits to send (0 treated as PAT_W)
- j  out  1  J drive to flip-flop (registered)
- k  out  1  K drive to flip-flop (registered)
- q  in  1  flip-flop output
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse when a pattern's last check completes
- err  out  1  sticky mismatch flag for current/last pattern, cleared at next pattern start
- err_cnt  out  ERR_W  total mismatches, saturates at all-ones

Behaviour:
- Reset (rst=0, async): j=0, k=0, busy=0, done=0, err=0, err_cnt=0, FIFO empty, q_model=0, check pipeline invalid, FSM=IDLE. The DUT flip-flop shares rst, so q=0 after reset.
- Handshake: push on pat_valid&&pat_ready. pat_ready = !full and is registered/derived from the count only, never from pat_valid. Offers while full are held by the source; nothing is dropped.
- Push and pop in the same cycle while full is legal: count is unchanged and pat_ready stays 0 that cycle.
- FSM states:
  - IDLE: if FIFO not empty, pop the entry into shift reg and bit counter (pat_len=0 -> PAT_W), clear err, go SHIFT. Else hold j=k=0.
  - SHIFT: each cycle take tgt = shift MSB, register j/k from (q_model, tgt), set q_model<=tgt, push (valid, tgt) into the 2-stage check pipe, shift left, decrement counter. After the last bit, go DRAIN.
  - DRAIN: j=k=0 (hold) for 2 cycles so the last checks retire, then go DONE.
  - DONE: pulse done for 1 cycle. If FIFO is not empty, pop the next entry directly (go SHIFT); else go IDLE.
- Excitation:
  - 0->0: j=0, k=0.
  - 1->1: j=0, k=0.
  - 0->1: j=1, k=0 (USE_TOGGLE=1: j=1, k=1).
  - 1->0: j=0, k=1 (USE_TOGGLE=1: j=1, k=1).
- Check timing:
  - j/k registered at edge n.
  - The FF updates q at edge n+1.
  - The sequencer samples q at edge n+2 and compares it with pipelined tgt.
  - On mismatch: err<=1, err_cnt+=1 unless saturated.
- Throughput: 1 bit/cycle. Pattern latency from pop to done = len+3 cycles.
- Back-to-back patterns: the 2 DRAIN cycles are always inserted; q_model is carried across patterns and never reset except by rst.
- Reset mid-pattern clears everything, including the FIFO. Partial checks are discarded, with no done pulse.

Decomposition:
- Package jk_pkg:
  - typedef enum {IDLE, SHIFT, DRAIN, DONE} jk_seq_state_e.
  - Function jk_excite(q_cur, q_nxt, use_toggle) returning {j,k}.
- Sub-module jk_pat_fifo (synchronous FIFO, DEPTH x (PAT_W+LEN_W), full/empty/count).
- FSM, shifter and checker live in the top level.

Test Plan:
- Reset: rst=0 for 2 cycles mid-run -> j=k=0, busy=0, err_cnt=0, pat_ready=1 immediately after release.
- Pattern 8'b1011_0010, len=8, USE_TOGGLE=0, real jk_ff -> j/k sequence (1,0),(0,1),(1,0),(0,0),(0,1),(0,0),(1,0),(0,1); q follows 1,0,1,1,0,0,1,0; done at pop+11; err=0.
- Same pattern with USE_TOGGLE=1 -> every transition is j=k=1 and holds are 0,0; q identical; err_cnt=0.
- Fault: the bench forces q=0 for the 3rd checked bit -> err=1, err_cnt=1; the next pattern start clears err, err_cnt stays 1.
- FIFO full: push 5 patterns of len=2 back-to-back with DEPTH=4 -> pat_ready deasserts after 4 accepted while the first is in SHIFT; all 5 eventually sent; 5 done pulses.
- pat_len=0 with pat_data=8'hFF -> 8 bits sent; only the first bit drives j=1; done after 11 cycles.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the JK excitation table for the JK pattern sequencer.
package jk_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} jk_seq_state_e;

  // Returns {j,k} that moves a JK flip-flop from q_cur to q_nxt.
  function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_nxt,
                                           input logic use_toggle);
    logic [1:0] jk;
    jk = 2'b00;
    if (q_cur != q_nxt) begin
      if (use_toggle) jk = 2'b11;
      else            jk = q_nxt ? 2'b10 : 2'b01;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_pat_fifo.sv
// Small synchronous FIFO holding {pattern, length} words for the JK sequencer.
module jk_pat_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push while full is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/jk_excite_seq.sv
// JK pattern sequencer: serializes buffered target patterns MSB-first into j/k
// drives for an external JK flip-flop and checks the returned q two cycles later.
module jk_excite_seq
  import jk_pkg::*;
#(
  parameter int PAT_W      = 8,
  parameter int LEN_W      = 4,
  parameter int DEPTH      = 4,
  parameter int USE_TOGGLE = 0,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  output logic             j,
  output logic             k,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FW = PAT_W + LEN_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(PAT_W + 1);

  jk_seq_state_e    state;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    fifo_rdata;
  logic [PAT_W-1:0] pop_data;
  logic [LEN_W-1:0] pop_len;
  logic [BW-1:0]    pop_cnt;

  logic [PAT_W-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             drain_cnt;
  logic             q_model;
  logic             vld_p0;
  logic             vld_p1;
  logic             tgt_p0;
  logic             tgt_p1;

  assign pat_ready = !fifo_full;
  assign fifo_pop  = ((state == IDLE) || (state == DONE)) && !fifo_empty;

  jk_pat_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pat_valid && pat_ready),
    .wdata ({pat_data, pat_len}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The top pop_cnt bits of the word are sent; length 0 (or oversize) means all PAT_W.
  assign pop_data = fifo_rdata[FW-1 -: PAT_W];
  assign pop_len  = fifo_rdata[LEN_W-1:0];

  always_comb begin
    pop_cnt = BW'(PAT_W);
    if ((pop_len != '0) && (int'(pop_len) < PAT_W)) pop_cnt = BW'(pop_len);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      drain_cnt <= 1'b0;
      q_model   <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      j      <= 1'b0;
      k      <= 1'b0;
      done   <= 1'b0;
      vld_p0 <= 1'b0;
      // p0 -> p1: the flip-flop consumes j/k during this cycle
      vld_p1 <= vld_p0;
      // p1 -> compare: q now reflects the j/k registered two edges ago
      if (vld_p1 && (q != tgt_p1)) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= pop_cnt;
            err     <= 1'b0;
          end
        end
        SHIFT: begin
          {j, k}  <= jk_excite(q_model, shreg[PAT_W-1], USE_TOGGLE != 0);
          q_model <= shreg[PAT_W-1];
          vld_p0  <= 1'b1;
          bit_cnt <= bit_cnt - BW'(1);
          if (bit_cnt == BW'(1)) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!fifo_empty) begin
            state   <= SHIFT;
            bit_cnt <= pop_cnt;
            err     <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; vld_p0/vld_p1 qualify them.
  always_ff @(posedge clk) begin
    tgt_p0 <= shreg[PAT_W-1];
    tgt_p1 <= tgt_p0;
    if (fifo_pop)
      shreg <= pop_data;
    else if (state == SHIFT)
      shreg <= {shreg[PAT_W-2:0], 1'b0};
  end

endmodule
